// File: rtl/rx_core_arbiter.sv
// -----------------------------------------------------------------------------
// rx_core_arbiter
//
// Shares the single router core between NUM_PORTS RX units. A round-robin
// picker selects one requesting port, grants it through a one-hot rc_ready,
// waits for that port's one-cycle rx_has_data pulse, then issues a one-cycle
// core_start tagged with the port index. No further grant is made until the
// core reports core_done. A grant that sees no pulse within TIMEOUT cycles is
// abandoned with a one-cycle grant_err.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   port_valid   per-port service request (level)
//   rx_has_data  per-port "packet captured" pulse from rx_handshake
//   rc_ready     one-hot grant to rx_handshake (registered)
//   core_start   one-cycle start pulse to the core
//   core_port    granted port index (0 while idle)
//   core_done    core finished current packet (looked at only while busy)
//   core_busy    high while the core owns a packet
//   grant_err    one-cycle pulse when a grant times out
//   served_cnt   packets handed to the core, wraps at 16 bits
// -----------------------------------------------------------------------------
module rx_core_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] port_valid,
  input  logic [NUM_PORTS-1:0] rx_has_data,
  output logic [NUM_PORTS-1:0] rc_ready,
  output logic                 core_start,
  output logic [PORT_W-1:0]    core_port,
  input  logic                 core_done,
  output logic                 core_busy,
  output logic                 grant_err,
  output logic [15:0]          served_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_PORTS-1:0]   rc_ready_q, rc_ready_d;
  logic                   core_start_q, core_start_d;
  logic [PORT_W-1:0]      core_port_q, core_port_d;
  logic                   core_busy_q, core_busy_d;
  logic                   grant_err_q, grant_err_d;
  logic [15:0]            served_q, served_d;
  logic [PORT_W-1:0]      last_ptr_q, last_ptr_d;
  logic [7:0]             timer_q, timer_d;

  logic                   pick_found;
  logic [PORT_W-1:0]      pick_idx;

  // Round-robin search: start one past the last granted port and wrap, so the
  // most recently granted port is always looked at last.
  function automatic logic [PORT_W:0] rr_pick(
    input logic [NUM_PORTS-1:0] req,
    input logic [PORT_W-1:0]    last
  );
    logic              found;
    logic [PORT_W-1:0] idx;
    logic [PORT_W-1:0] cand_idx;
    int                cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand     = (int'(last) + i) % NUM_PORTS;
      cand_idx = PORT_W'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    {pick_found, pick_idx} = rr_pick(port_valid, last_ptr_q);
  end

  // Next-state and next-output logic. Every output is a register, so the
  // values computed here appear one cycle later.
  always_comb begin
    state_d      = state_q;
    rc_ready_d   = rc_ready_q;
    core_start_d = 1'b0;
    core_port_d  = core_port_q;
    core_busy_d  = core_busy_q;
    grant_err_d  = 1'b0;
    served_d     = served_q;
    last_ptr_d   = last_ptr_q;
    timer_d      = timer_q;

    unique case (state_q)
      S_IDLE: begin
        rc_ready_d  = '0;
        core_busy_d = 1'b0;
        core_port_d = '0;
        if (pick_found) begin
          rc_ready_d  = NUM_PORTS'(1) << pick_idx;
          core_port_d = pick_idx;
          timer_d     = '0;
          state_d     = S_GRANT;
        end
      end

      S_GRANT: begin
        timer_d = timer_q + 8'd1;
        // Only the granted port's pulse counts; it also beats a timeout
        // landing in the same cycle.
        if (rx_has_data[core_port_q]) begin
          rc_ready_d   = '0;
          core_start_d = 1'b1;
          core_busy_d  = 1'b1;
          served_d     = served_q + 16'd1;
          state_d      = S_BUSY;
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          rc_ready_d  = '0;
          grant_err_d = 1'b1;
          last_ptr_d  = core_port_q;
          core_port_d = '0;
          state_d     = S_IDLE;
        end
      end

      S_BUSY: begin
        rc_ready_d  = '0;
        core_busy_d = 1'b1;
        if (core_done) begin
          last_ptr_d  = core_port_q;
          core_port_d = '0;
          core_busy_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        rc_ready_d  = '0;
        core_port_d = '0;
        core_busy_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rc_ready_q   <= '0;
      core_start_q <= 1'b0;
      core_port_q  <= '0;
      core_busy_q  <= 1'b0;
      grant_err_q  <= 1'b0;
      served_q     <= '0;
      last_ptr_q   <= PORT_W'(NUM_PORTS - 1);
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      rc_ready_q   <= rc_ready_d;
      core_start_q <= core_start_d;
      core_port_q  <= core_port_d;
      core_busy_q  <= core_busy_d;
      grant_err_q  <= grant_err_d;
      served_q     <= served_d;
      last_ptr_q   <= last_ptr_d;
      timer_q      <= timer_d;
    end
  end

  assign rc_ready   = rc_ready_q;
  assign core_start = core_start_q;
  assign core_port  = core_port_q;
  assign core_busy  = core_busy_q;
  assign grant_err  = grant_err_q;
  assign served_cnt = served_q;

endmodule

// File: tb/tb_rx_core_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rx_core_arbiter
//
// Directed bench for rx_core_arbiter (NUM_PORTS=4, TIMEOUT=15). Inputs are
// driven and outputs sampled on the falling clock edge; each scenario task
// carries its own hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_rx_core_arbiter;
  localparam int NP = 4;
  localparam int PW = 2;
  localparam int TO = 15;

  logic          clk;
  logic          rst_n;
  logic [NP-1:0] port_valid;
  logic [NP-1:0] rx_has_data;
  logic [NP-1:0] rc_ready;
  logic          core_start;
  logic [PW-1:0] core_port;
  logic          core_done;
  logic          core_busy;
  logic          grant_err;
  logic [15:0]   served_cnt;

  int total = 0;
  int bad   = 0;

  rx_core_arbiter #(.NUM_PORTS(NP), .PORT_W(PW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .port_valid  (port_valid),
    .rx_has_data (rx_has_data),
    .rc_ready    (rc_ready),
    .core_start  (core_start),
    .core_port   (core_port),
    .core_done   (core_done),
    .core_busy   (core_busy),
    .grant_err   (grant_err),
    .served_cnt  (served_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance until a grant shows up (bounded); report which port holds it.
  task automatic wait_grant(output int port, output bit ok);
    ok   = 1'b0;
    port = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (rc_ready != '0) begin
        ok = 1'b1;
        for (int j = 0; j < NP; j++) if (rc_ready[j]) port = j;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    port_valid  = '0;
    rx_has_data = '0;
    core_done   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (rc_ready !== 4'b0000) begin bad++; $display("FAIL rst_rc_ready got=%b want=0000", rc_ready); end
    total++; if (core_start !== 1'b0) begin bad++; $display("FAIL rst_core_start got=%b want=0", core_start); end
    total++; if (core_port !== 2'd0) begin bad++; $display("FAIL rst_core_port got=%0d want=0", core_port); end
    total++; if (core_busy !== 1'b0) begin bad++; $display("FAIL rst_core_busy got=%b want=0", core_busy); end
    total++; if (grant_err !== 1'b0) begin bad++; $display("FAIL rst_grant_err got=%b want=0", grant_err); end
    total++; if (served_cnt !== 16'd0) begin bad++; $display("FAIL rst_served got=%0d want=0", served_cnt); end
  endtask

  task automatic test_single();
    int p; bit ok;
    port_valid = 4'b0100;
    wait_grant(p, ok);
    total++; if (!ok) begin bad++; $display("FAIL t1_wait got=timeout want=grant"); return; end
    total++; if (rc_ready !== 4'b0100) begin bad++; $display("FAIL t1_rc_ready got=%b want=0100", rc_ready); end
    total++; if (core_port !== 2'd2) begin bad++; $display("FAIL t1_core_port got=%0d want=2", core_port); end
    port_valid     = '0;
    rx_has_data[2] = 1'b1;
    @(negedge clk);
    rx_has_data = '0;
    total++; if (core_start !== 1'b1) begin bad++; $display("FAIL t1_core_start got=%b want=1", core_start); end
    total++; if (served_cnt !== 16'd1) begin bad++; $display("FAIL t1_served got=%0d want=1", served_cnt); end
    total++; if (core_busy !== 1'b1 || rc_ready !== 4'b0000) begin bad++; $display("FAIL t1_busy got=%b/%b want=1/0000", core_busy, rc_ready); end
    @(negedge clk);
    total++; if (core_start !== 1'b0 || core_busy !== 1'b1) begin bad++; $display("FAIL t1_start_once got=%b/%b want=0/1", core_start, core_busy); end
    repeat (3) @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    total++; if (core_busy !== 1'b0 || core_port !== 2'd0 || rc_ready !== 4'b0000) begin bad++; $display("FAIL t1_done got=busy%b port%0d rdy%b want=0/0/0000", core_busy, core_port, rc_ready); end
  endtask

  task automatic test_round_robin();
    int p; int prev; bit ok;
    apply_reset();
    port_valid = 4'b1111;
    prev = -1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(p, ok);
      total++; if (!ok) begin bad++; $display("FAIL t2_wait%0d got=timeout want=grant", k); port_valid = '0; return; end
      total++; if (p != k % 4) begin bad++; $display("FAIL t2_order%0d got=%0d want=%0d", k, p, k % 4); end
      total++; if (p == prev) begin bad++; $display("FAIL t2_repeat%0d got=%0d want=not %0d", k, p, prev); end
      prev = p;
      if (k == 4) port_valid = '0;
      rx_has_data[p] = 1'b1;
      @(negedge clk);
      rx_has_data = '0;
      total++; if (core_start !== 1'b1 || core_port !== PW'(p)) begin bad++; $display("FAIL t2_start%0d got=%b/%0d want=1/%0d", k, core_start, core_port, p); end
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
    end
    total++; if (served_cnt !== 16'd5) begin bad++; $display("FAIL t2_served got=%0d want=5", served_cnt); end
  endtask

  task automatic test_timeout();
    int p; bit ok;
    port_valid = 4'b1010;
    wait_grant(p, ok);
    total++; if (!ok || p != 1) begin bad++; $display("FAIL t3_grant got=%0d want=1", p); end
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      total++; if (rc_ready !== 4'b0010 || grant_err !== 1'b0) begin bad++; $display("FAIL t3_hold%0d got=%b/%b want=0010/0", i, rc_ready, grant_err); end
    end
    @(negedge clk);
    total++; if (rc_ready !== 4'b0000) begin bad++; $display("FAIL t3_drop got=%b want=0000", rc_ready); end
    total++; if (grant_err !== 1'b1) begin bad++; $display("FAIL t3_err got=%b want=1", grant_err); end
    total++; if (served_cnt !== 16'd5) begin bad++; $display("FAIL t3_served got=%0d want=5", served_cnt); end
    @(negedge clk);
    total++; if (grant_err !== 1'b0) begin bad++; $display("FAIL t3_err_once got=%b want=0", grant_err); end
    total++; if (rc_ready !== 4'b1000 || core_port !== 2'd3) begin bad++; $display("FAIL t3_next got=%b/%0d want=1000/3", rc_ready, core_port); end
  endtask

  // Runs on from test_timeout: port 3 was granted one edge ago (timer=0).
  task automatic test_simultaneous();
    port_valid     = '0;
    rx_has_data[1] = 1'b1;
    @(negedge clk);
    rx_has_data = '0;
    total++; if (rc_ready !== 4'b1000 || core_start !== 1'b0) begin bad++; $display("FAIL t4_ignore got=%b/%b want=1000/0", rc_ready, core_start); end
    repeat (TO - 2) @(negedge clk);
    total++; if (rc_ready !== 4'b1000) begin bad++; $display("FAIL t4_still got=%b want=1000", rc_ready); end
    rx_has_data[3] = 1'b1;
    @(negedge clk);
    rx_has_data = '0;
    total++; if (core_start !== 1'b1 || core_busy !== 1'b1) begin bad++; $display("FAIL t4_start got=%b/%b want=1/1", core_start, core_busy); end
    total++; if (grant_err !== 1'b0) begin bad++; $display("FAIL t4_no_err got=%b want=0", grant_err); end
    total++; if (core_port !== 2'd3 || served_cnt !== 16'd6) begin bad++; $display("FAIL t4_port_cnt got=%0d/%0d want=3/6", core_port, served_cnt); end
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    total++; if (core_busy !== 1'b0 || grant_err !== 1'b0 || core_port !== 2'd0) begin bad++; $display("FAIL t4_done got=%b/%b/%0d want=0/0/0", core_busy, grant_err, core_port); end
  endtask

  task automatic test_reset_busy();
    int p; bit ok;
    port_valid = 4'b0001;
    wait_grant(p, ok);
    total++; if (!ok || p != 0) begin bad++; $display("FAIL t5_grant got=%0d want=0", p); end
    port_valid     = '0;
    rx_has_data[0] = 1'b1;
    @(negedge clk);
    rx_has_data = '0;
    total++; if (served_cnt !== 16'd7 || core_busy !== 1'b1) begin bad++; $display("FAIL t5_pre got=%0d/%b want=7/1", served_cnt, core_busy); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (core_busy !== 1'b0 || core_port !== 2'd0 || rc_ready !== 4'b0000) begin bad++; $display("FAIL t5_async got=%b/%0d/%b want=0/0/0000", core_busy, core_port, rc_ready); end
    total++; if (served_cnt !== 16'd0 || core_start !== 1'b0 || grant_err !== 1'b0) begin bad++; $display("FAIL t5_async_cnt got=%0d/%b/%b want=0/0/0", served_cnt, core_start, grant_err); end
    @(negedge clk);
    rst_n      = 1'b1;
    port_valid = 4'b0011;
    wait_grant(p, ok);
    total++; if (!ok || p != 0) begin bad++; $display("FAIL t5_first got=%0d want=0", p); end
    port_valid     = '0;
    rx_has_data[0] = 1'b1;
    @(negedge clk);
    rx_has_data = '0;
    total++; if (served_cnt !== 16'd1) begin bad++; $display("FAIL t5_served got=%0d want=1", served_cnt); end
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  task automatic test_wrap();
    int p; bit ok;
    force dut.served_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.served_q;
    @(negedge clk);
    total++; if (served_cnt !== 16'hFFFF) begin bad++; $display("FAIL t6_preload got=%h want=ffff", served_cnt); end
    port_valid = 4'b0100;
    wait_grant(p, ok);
    total++; if (!ok || p != 2) begin bad++; $display("FAIL t6_grant got=%0d want=2", p); end
    port_valid     = '0;
    rx_has_data[2] = 1'b1;
    @(negedge clk);
    rx_has_data = '0;
    total++; if (served_cnt !== 16'h0000) begin bad++; $display("FAIL t6_wrap got=%h want=0000", served_cnt); end
    total++; if (core_start !== 1'b1 || core_port !== 2'd2) begin bad++; $display("FAIL t6_start got=%b/%0d want=1/2", core_start, core_port); end
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    total++; if (core_busy !== 1'b0 || rc_ready !== 4'b0000) begin bad++; $display("FAIL t6_done got=%b/%b want=0/0000", core_busy, rc_ready); end
  endtask

  initial begin
    rst_n       = 1'b0;
    port_valid  = '0;
    rx_has_data = '0;
    core_done   = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_simultaneous();
    test_reset_busy();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_core_arbiter.md
Name: rx_core_arbiter

Overview:
Shares the single router core between NUM_PORTS RX units, each fronted by its own rx_handshake instance. Grants one port at a time by driving that port's rc_ready, using round-robin priority. Converts the port's one-cycle rx_has_data pulse into a core_start command tagged with the port index, then holds off further grants until the core reports core_done. Sits between the rx_handshake array and the routercore datapath.

Parameters:
NUM_PORTS, 4, number of RX ports arbitrated (2..16)
PORT_W, 2, width of the port index; must equal ceil(log2(NUM_PORTS))
TIMEOUT, 15, GRANT-state cycles allowed for rx_has_data before the grant is abandoned (1..255)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
port_valid  in  NUM_PORTS  RX_Data_Valid from each RX unit; a port requests service while its bit is high
rx_has_data  in  NUM_PORTS  one-cycle "packet captured" pulse from each port's rx_handshake
rc_ready  out  NUM_PORTS  one-hot grant to each rx_handshake; registered
core_start  out  1  one-cycle pulse: the core begins processing the packet from core_port
core_port  out  PORT_W  index of the granted port; valid in GRANT and BUSY, 0 in IDLE
core_done  in  1  core finished the current packet; sampled only in BUSY
core_busy  out  1  high in BUSY
grant_err  out  1  one-cycle pulse on grant timeout
served_cnt  out  16  packets delivered to the core (one count per core_start); wraps 0xFFFF->0

Behaviour:
- Reset values: state=IDLE, rc_ready=0, core_start=0, core_port=0, core_busy=0, grant_err=0, served_cnt=0, last_ptr=NUM_PORTS-1, timer=0. After reset, port 0 has highest priority.
- All outputs are registered; no combinational input-to-output path.
- FSM states and transitions:
- IDLE: rc_ready=0. If any port_valid bit is high, pick the first set bit scanning last_ptr+1, last_ptr+2, ... modulo NUM_PORTS. Load g, set core_port=g and rc_ready[g]=1 at the same edge, clear timer, go to GRANT. If no bit is high, stay in IDLE.
- GRANT: rc_ready stays one-hot on g; timer increments each cycle.
  - If rx_has_data[g]=1: clear rc_ready, set core_start=1 for the next cycle only, increment served_cnt, go to BUSY.
  - Else if timer==TIMEOUT-1: clear rc_ready, pulse grant_err for one cycle, set last_ptr=g, go to IDLE.
  - rx_has_data on any non-granted port is ignored.
  - port_valid[g] dropping during GRANT does not end the grant; only the pulse or the timeout ends it.
- BUSY: core_busy=1; core_start is high only in the first BUSY cycle. core_done is sampled every BUSY cycle, including the first. When core_done=1: set last_ptr=g, go to IDLE, core_busy=0 and core_port=0 at that edge. rc_ready stays 0 for the whole BUSY state.
- Expected handshake latency with rx_handshake: rc_ready rises at edge N, and rx_has_data[g] is seen high in cycle N+1. With a timely pulse, the minimum cycles from the IDLE decision to core_start is 3.
- Fairness: after any grant ends (served or timed out), the granted port gets lowest priority. A port continuously requesting is served at least once every NUM_PORTS grants.
- Minimum IDLE dwell between grants is 1 cycle. Back-to-back service (BUSY -> IDLE -> GRANT) is legal.
- Simultaneous events:
  - rx_has_data[g] and timeout in the same cycle: rx_has_data wins, no grant_err.
  - core_done while not in BUSY: ignored.
- Async reset asserted mid-GRANT or mid-BUSY: immediate return to all reset values, including served_cnt. The core is expected to be reset by the same rst_n.
- served_cnt is unsigned 16-bit and wraps silently.

Test Plan:
1. Reset, then port_valid=4'b0100; a model rx_handshake pulses rx_has_data[2] one cycle after rc_ready[2] rises -> core_start pulses with core_port=2, served_cnt=1; core_done after 5 cycles -> IDLE, rc_ready=0.
2. port_valid=4'b1111 held, with 4 served packets -> grant order 0,1,2,3, then 0 again; never two consecutive grants to the same port.
3. Granted port never pulses rx_has_data, TIMEOUT=15 -> rc_ready drops exactly 15 cycles after rising, grant_err pulses once, served_cnt unchanged, next grant goes to the next requesting port.
4. rx_has_data[1] pulsed while port 3 is granted -> ignored. Then rx_has_data[3] arrives in the same cycle the timer hits TIMEOUT-1 -> BUSY, no grant_err.
5. Assert rst_n=0 in the middle of BUSY with served_cnt=7 -> all outputs 0 immediately, served_cnt=0, and the next grant goes to port 0.
6. Preload served_cnt to 0xFFFF via 65535 packets, or force it in simulation; serve one more packet -> served_cnt=0x0000, behaviour otherwise normal.
